bldc_commutator: RTL

Six-step commutation sequencer for the BLDC power stage. It filters the three hall inputs, picks the active high-side and low-side legs from the hall code and the sign of the duty command, and PWMs the high-side switch. It inserts dead-time on every pattern change and latches illegal hall codes as a fault. It sits between the position/PID control path (signed duty command) and the 6-bit PHASES gate bus.

---
 rtl/bldc_commutator.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/bldc_commutator.sv
// rtl/bldc_commutator.sv - six-step BLDC commutator: hall filter, dead-time, PWM, illegal-hall fault
// Optional feature macro: BLDC_COMMUTATOR_SYNC_RECT_EN (synchronous rectification on the switched leg)
module bldc_commutator #(
  parameter int PWM_PERIOD  = 800,
  parameter int DEADTIME    = 16,
  parameter int HALL_FILTER = 4
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               hall1,
  input  logic               hall2,
  input  logic               hall3,
  input  logic               enable,
  input  logic signed [15:0] duty,
  output logic [5:0]         PHASES,
  output logic [2:0]         sector,
  output logic               fault,
  output logic               pwm_sync
);
  localparam int FW = $clog2(HALL_FILTER + 1);
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [15:0]   PERIOD_M1 = 16'(PWM_PERIOD - 1);
  localparam logic [16:0]   PERIOD_W  = 17'(PWM_PERIOD);
  localparam logic [FW-1:0] FILT      = FW'(HALL_FILTER);
  localparam logic [DW-1:0] DEAD_M1   = DW'(DEADTIME - 1);
`ifdef BLDC_COMMUTATOR_SYNC_RECT_EN
  localparam int DT4 = (DEADTIME / 4 > 0) ? DEADTIME / 4 : 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_RUN, S_FAULT} state_t;

  logic [2:0]    sync1, sync2, cand, code;
  logic [1:0]    sync_vld;
  logic [FW-1:0] stab_cnt, stab_nxt;
  logic          code_vld;
  logic [15:0]   pwm_cnt, mag, cnt_nxt, mag_nxt, mag_sat;
  logic [16:0]   duty_abs;
  logic          dir, dir_nxt;
  logic [1:0]    fwd_hi, fwd_lo, hi_leg, lo_leg;
  logic [2:0]    code_sector;
  logic          code_legal, code_bad;
  logic [5:0]    drive;
  logic [3:0]    tgt, pat;
  logic [DW-1:0] dead_cnt;
  state_t        state;

  // Stability count: restarts on any change of the synchronized sample
  always_comb begin
    if (sync2 != cand)         stab_nxt = FW'(1);
    else if (stab_cnt == FILT) stab_nxt = stab_cnt;
    else                       stab_nxt = stab_cnt + FW'(1);
  end

  // Two-flop synchronizer, then accept a code once it has been stable HALL_FILTER samples
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1    <= 3'b000;
      sync2    <= 3'b000;
      sync_vld <= 2'b00;
      cand     <= 3'b000;
      stab_cnt <= '0;
      code     <= 3'b000;
      code_vld <= 1'b0;
    end else begin
      sync1    <= {hall3, hall2, hall1};
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1]) begin
        cand     <= sync2;
        stab_cnt <= stab_nxt;
        if (stab_nxt == FILT) begin
          code     <= sync2;
          code_vld <= 1'b1;
        end
      end
    end
  end

  // Next PWM counter and duty latch; magnitude and sign are taken only in the counter-0 cycle
  always_comb begin
    duty_abs = duty[15] ? ({1'b0, ~duty} + 17'd1) : {1'b0, duty};
    mag_sat  = (duty_abs > PERIOD_W) ? 16'(PWM_PERIOD) : duty_abs[15:0];
    cnt_nxt  = (pwm_cnt == PERIOD_M1) ? 16'd0 : pwm_cnt + 16'd1;
    mag_nxt  = (pwm_cnt == 16'd0) ? mag_sat : mag;
    dir_nxt  = (pwm_cnt == 16'd0) ? duty[15] : dir;
  end

  // PWM carrier, latched duty and the wrap pulse
  always_ff @(posedge CLK) begin
    if (reset) begin
      pwm_cnt  <= 16'd0;
      mag      <= 16'd0;
      dir      <= 1'b0;
      pwm_sync <= 1'b0;
    end else begin
      pwm_cnt  <= cnt_nxt;
      mag      <= mag_nxt;
      dir      <= dir_nxt;
      pwm_sync <= (cnt_nxt == 16'd0);
    end
  end

  // Hall code to legs and sector; reverse swaps legs. Gate pattern is for the upcoming cycle.
  always_comb begin
    fwd_hi      = 2'd0;
    fwd_lo      = 2'd0;
    code_sector = 3'd7;
    case (code)
      3'b101: begin fwd_hi = 2'd0; fwd_lo = 2'd1; code_sector = 3'd0; end
      3'b100: begin fwd_hi = 2'd0; fwd_lo = 2'd2; code_sector = 3'd1; end
      3'b110: begin fwd_hi = 2'd1; fwd_lo = 2'd2; code_sector = 3'd2; end
      3'b010: begin fwd_hi = 2'd1; fwd_lo = 2'd0; code_sector = 3'd3; end
      3'b011: begin fwd_hi = 2'd2; fwd_lo = 2'd0; code_sector = 3'd4; end
      3'b001: begin fwd_hi = 2'd2; fwd_lo = 2'd1; code_sector = 3'd5; end
      default: ;
    endcase
    hi_leg     = dir_nxt ? fwd_lo : fwd_hi;
    lo_leg     = dir_nxt ? fwd_hi : fwd_lo;
    code_bad   = code_vld && ((code == 3'b000) || (code == 3'b111));
    code_legal = code_vld && !code_bad;
    drive      = 6'b000000;
    if (mag_nxt != 16'd0) begin
`ifdef BLDC_COMMUTATOR_SYNC_RECT_EN
      drive[{1'b0, hi_leg}]          = (cnt_nxt >= 16'(DT4)) && (cnt_nxt < mag_nxt);
      drive[3'd3 + {1'b0, hi_leg}]   = ({1'b0, cnt_nxt} >= ({1'b0, mag_nxt} + 17'(DT4)));
      drive[3'd3 + {1'b0, lo_leg}]   = 1'b1;
`else
      drive[{1'b0, hi_leg}]          = (cnt_nxt < mag_nxt);
      drive[3'd3 + {1'b0, lo_leg}]   = 1'b1;
`endif
    end
  end

  assign tgt = {code, dir_nxt};

  // Commutation FSM: dead-time on every target change, sticky fault until enable drops
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= S_IDLE;
      dead_cnt <= '0;
      pat      <= 4'd0;
      PHASES   <= 6'b000000;
      sector   <= 3'd7;
      fault    <= 1'b0;
    end else if (!enable) begin
      state    <= S_IDLE;
      dead_cnt <= '0;
      PHASES   <= 6'b000000;
      sector   <= code_sector;
      fault    <= 1'b0;
    end else if (code_bad) begin
      state  <= S_FAULT;
      PHASES <= 6'b000000;
      sector <= 3'd7;
      fault  <= 1'b1;
    end else begin
      sector <= (state == S_FAULT) ? 3'd7 : code_sector;
      case (state)
        S_IDLE: begin
          PHASES <= 6'b000000;
          if (code_legal) begin
            state    <= S_DEAD;
            dead_cnt <= '0;
            pat      <= tgt;
          end
        end
        S_DEAD: begin
          PHASES <= 6'b000000;
          if (tgt != pat) begin
            dead_cnt <= '0;
            pat      <= tgt;
          end else if (dead_cnt == DEAD_M1) begin
            state  <= S_RUN;
            PHASES <= drive;
          end else begin
            dead_cnt <= dead_cnt + DW'(1);
          end
        end
        S_RUN: begin
          if (tgt != pat) begin
            state    <= S_DEAD;
            dead_cnt <= '0;
            pat      <= tgt;
            PHASES   <= 6'b000000;
          end else begin
            PHASES <= drive;
          end
        end
        S_FAULT: PHASES <= 6'b000000;
        default: begin
          state  <= S_IDLE;
          PHASES <= 6'b000000;
        end
      endcase
    end
  end
endmodule
